// File: rtl/cpu_param_pkg.sv
// Shared opcode map and widths for the parametrised teaching CPU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_param_pkg;

  localparam int OPW = 4;

  typedef enum logic [OPW-1:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_AI = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_BI = 4'b0111,
    OP_HLT    = 4'b1000,
    OP_OUT_B  = 4'b1001,
    OP_NOP_A  = 4'b1010,
    OP_OUT_I  = 4'b1011,
    OP_NOP_C  = 4'b1100,
    OP_NOP_D  = 4'b1101,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } opcode_e;

endpackage

// File: rtl/cpu_param_alu.sv
// DW-bit adder shared by ADD A,imm and ADD B,imm; operand picked from A or B.
// Latency: combinational.
// Backpressure: none; purely combinational.
module cpu_param_alu
  import cpu_param_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  input  logic          sel_b,
  output logic [DW-1:0] sum,
  output logic          cout
);

  logic [DW-1:0] opnd;

  assign opnd        = sel_b ? b : a;
  // Extend by one bit so the top bit of the result is the carry-out.
  assign {cout, sum} = {1'b0, opnd} + {1'b0, imm};

endmodule

// File: rtl/cpu_param.sv
// Parametrised 4-bit-opcode CPU: registers A/B, carry, PC, LED port; optional HLT via CPU_PARAM_HALT_EN.
// Latency: one instruction per clock, effects visible after the executing edge.
// Backpressure: inst_valid=0 stalls all state; a halted core freezes until rst.
module cpu_param
  import cpu_param_pkg::*;
#(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] inst_opcode,
  input  logic [DW-1:0]  inst_imm,
  input  logic           inst_valid,
  input  logic [DW-1:0]  switch,
  output logic [AW-1:0]  pc,
  output logic [DW-1:0]  led,
  output logic           carry,
  output logic           halted
);

  logic [DW-1:0] a_q, b_q;
  logic [DW-1:0] a_nxt, b_nxt, led_nxt;
  logic [AW-1:0] pc_nxt, target;
  logic          c_nxt;
  logic          alu_sel_b;
  logic [DW-1:0] alu_sum;
  logic          alu_cout;
  logic          exec;
  opcode_e       op;

  assign op     = opcode_e'(inst_opcode);
  // Size cast zero-extends a narrow immediate and truncates a wide one.
  assign target = AW'(inst_imm);
  assign exec   = inst_valid & ~halted;

  cpu_param_alu #(.DW(DW)) u_alu (
    .a     (a_q),
    .b     (b_q),
    .imm   (inst_imm),
    .sel_b (alu_sel_b),
    .sum   (alu_sum),
    .cout  (alu_cout)
  );

`ifdef CPU_PARAM_HALT_EN
  logic halt_set;
  logic halted_q;

  // Sticky halt flag; only reset releases it.
  always_ff @(posedge clk) begin
    if (rst)
      halted_q <= 1'b0;
    else if (exec && halt_set)
      halted_q <= 1'b1;
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // Decode: next-state for every register; non-ADD instructions clear carry.
  always_comb begin
    a_nxt     = a_q;
    b_nxt     = b_q;
    led_nxt   = led;
    c_nxt     = 1'b0;
    pc_nxt    = pc + AW'(1);
    alu_sel_b = 1'b0;
`ifdef CPU_PARAM_HALT_EN
    halt_set  = 1'b0;
`endif
    case (op)
      OP_ADD_A:  begin a_nxt = alu_sum; c_nxt = alu_cout; end
      OP_MOV_AB: a_nxt = b_q;
      OP_IN_A:   a_nxt = switch;
      OP_MOV_AI: a_nxt = inst_imm;
      OP_MOV_BA: b_nxt = a_q;
      OP_ADD_B:  begin alu_sel_b = 1'b1; b_nxt = alu_sum; c_nxt = alu_cout; end
      OP_IN_B:   b_nxt = switch;
      OP_MOV_BI: b_nxt = inst_imm;
      OP_OUT_B:  led_nxt = b_q;
      OP_OUT_I:  led_nxt = inst_imm;
      // JNC looks at the carry from the previous instruction, before this clear.
      OP_JNC:    if (!carry) pc_nxt = target;
      OP_JMP:    pc_nxt = target;
`ifdef CPU_PARAM_HALT_EN
      OP_HLT:    begin halt_set = 1'b1; pc_nxt = pc; end
`endif
      default:   ;
    endcase
  end

  // Architectural state: reset wins, otherwise update only on an executing cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      pc    <= '0;
      led   <= '0;
    end else if (exec) begin
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      carry <= c_nxt;
      pc    <= pc_nxt;
      led   <= led_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_param.sv
// Scoreboard bench for cpu_param: directed program fragments followed by random instruction streams.
// A behavioural model predicts pc/led/carry/halted after every edge; a monitor compares after each edge.
// Halt behaviour is predicted according to whether CPU_PARAM_HALT_EN is defined.
module tb_cpu_param;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int DMOD = 2 ** DW;
  localparam int AMOD = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    inst_opcode = '0;
  logic [DW-1:0] inst_imm = '0;
  logic          inst_valid = 1'b0;
  logic [DW-1:0] switch = '0;
  logic [AW-1:0] pc;
  logic [DW-1:0] led;
  logic          carry;
  logic          halted;

  cpu_param #(.DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_opcode (inst_opcode),
    .inst_imm    (inst_imm),
    .inst_valid  (inst_valid),
    .switch      (switch),
    .pc          (pc),
    .led         (led),
    .carry       (carry),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int led;
    int carry;
    int halted;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   errors = 0;

  // Reference model state, plain integers.
  int m_a = 0, m_b = 0, m_c = 0, m_pc = 0, m_led = 0, m_h = 0;

  task automatic check(string name, int got, int want);
    tests++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  // Monitor: after every rising edge, compare against the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("pc",     int'(pc),     e.pc);
        check("led",    int'(led),    e.led);
        check("carry",  int'(carry),  e.carry);
        check("halted", int'(halted), e.halted);
      end
    end
  end

  // Drive one cycle of inputs and push the state expected after the next edge.
  task automatic step(input bit r, input bit v, input int op, input int imm, input int sw);
    exp_t e;
    int   npc, nc, s;
    @(negedge clk);
    rst         = r;
    inst_valid  = v;
    inst_opcode = 4'(op);
    inst_imm    = DW'(imm);
    switch      = DW'(sw);
    if (r) begin
      m_a = 0; m_b = 0; m_c = 0; m_pc = 0; m_led = 0; m_h = 0;
    end else if (v && m_h == 0) begin
      npc = (m_pc + 1) % AMOD;
      nc  = 0;
      case (op)
        0:  begin s = m_a + imm; nc = (s >= DMOD); m_a = s % DMOD; end
        1:  m_a = m_b;
        2:  m_a = sw;
        3:  m_a = imm;
        4:  m_b = m_a;
        5:  begin s = m_b + imm; nc = (s >= DMOD); m_b = s % DMOD; end
        6:  m_b = sw;
        7:  m_b = imm;
        9:  m_led = m_b;
        11: m_led = imm;
        14: if (m_c == 0) npc = imm % AMOD;
        15: npc = imm % AMOD;
`ifdef CPU_PARAM_HALT_EN
        8:  begin m_h = 1; npc = m_pc; end
`endif
        default: ;
      endcase
      m_c  = nc;
      m_pc = npc;
    end
    e.pc = m_pc; e.led = m_led; e.carry = m_c; e.halted = m_h;
    exp_q.push_back(e);
  endtask

  task automatic run(input int op, input int imm);
    step(0, 1, op, imm, int'(switch));
  endtask

  initial begin
    // Reset for two cycles with arbitrary instruction fields.
    for (int i = 0; i < 2; i++)
      step(1, 1, int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)));

    // Carry then branch: MOV A,3; ADD A,14; JNC 9 (not taken); JNC 9 (taken).
    run(3, 3);
    run(0, 14);
    run(14, 9);
    run(14, 9);

    // I/O path via switch=3, then OUT imm 10.
    step(0, 1, 2, 0, 3);
    run(4, 0);
    run(9, 0);
    run(11, 10);

    // Stall three cycles with garbage instruction fields, then resume.
    run(3, 7);
    for (int i = 0; i < 3; i++)
      step(0, 0, 11, int'($urandom_range(15)), int'($urandom_range(15)));
    run(5, 9);
    run(4, 0);

    // Wrap: JMP 15, NOP -> pc 0; A=15 plus 1 -> 0 with carry; show A on led.
    run(15, 15);
    run(10, 0);
    run(3, 15);
    run(0, 1);
    run(1, 0);
    run(7, 0);
    run(5, 0);
    run(4, 0);
    run(9, 0);

    // Halt (or NOP) at pc=4, then ten cycles of arbitrary traffic, then reset.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) run(12, 0);
    run(8, 0);
    for (int i = 0; i < 10; i++)
      step(0, int'($urandom_range(1)), int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)));
    step(1, 1, 8, 0, 0);

    // Random streams with occasional stalls and resets.
    for (int i = 0; i < 3000; i++) begin
      bit r, v;
      r = ($urandom_range(63) == 0);
      v = ($urandom_range(9) != 0);
      step(r, v, int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)));
    end

    // Drain: the monitor must consume every prediction within a few cycles.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
